demultiplexer4x4_buf: RTL and testbench

DEMULTIPLEXER4X4_BUF -- requirements
Module: demultiplexer4x4_buf

---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_slot.sv | 63 ++++++
 rtl/demultiplexer4x4_buf.sv | 85 ++++++++
 tb/tb_demultiplexer4x4_buf.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg : shared defaults and channel index type for the 4-way demux
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package demux_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;
  localparam int NUM_CH    = 4;

  typedef logic [1:0] ch_idx_t;
endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// ---------------------------------------------------------------------------
// demux_slot : one-entry output register with valid/ready and delivery count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module demux_slot #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             ready_i,
  output logic             accept_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_drain;

  assign w_drain  = full_q & ready_i;
  // Room exists if empty, or if the held word leaves on this same edge.
  assign accept_o = ~full_q | ready_i;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    cnt_d  = cnt_q;
    if (w_drain) begin
      full_d = 1'b0;
      cnt_d  = cnt_q + 1'b1;
    end
    if (load_i) begin
      full_d = 1'b1;
      data_d = din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign valid_o = full_q;
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;

endmodule

`default_nettype wire

// File: rtl/demultiplexer4x4_buf.sv
// ---------------------------------------------------------------------------
// demultiplexer4x4_buf : routes din to one of four buffered output channels
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module demultiplexer4x4_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic             v0,
  output logic             v1,
  output logic             v2,
  output logic             v3,
  input  logic             r0,
  input  logic             r1,
  input  logic             r2,
  input  logic             r3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
);

  logic [NUM_CH-1:0] w_load;
  logic [NUM_CH-1:0] w_accept;
  logic [NUM_CH-1:0] w_ready;
  logic [NUM_CH-1:0] w_valid;
  logic [WIDTH-1:0]  w_data [NUM_CH];
  logic [CNT_W-1:0]  w_cnt  [NUM_CH];
  ch_idx_t           w_sel;

  assign w_sel    = sel;
  assign w_ready  = {r3, r2, r1, r0};
  assign in_ready = rst_n & w_accept[w_sel];

  always_comb begin
    w_load        = '0;
    w_load[w_sel] = in_valid & in_ready;
  end

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
      demux_slot #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
      ) u_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (w_load[k]),
        .din_i    (din),
        .ready_i  (w_ready[k]),
        .accept_o (w_accept[k]),
        .valid_o  (w_valid[k]),
        .data_o   (w_data[k]),
        .cnt_o    (w_cnt[k])
      );
    end
  endgenerate

  assign {v3, v2, v1, v0} = w_valid;
  assign y0   = w_data[0];
  assign y1   = w_data[1];
  assign y2   = w_data[2];
  assign y3   = w_data[3];
  assign cnt0 = w_cnt[0];
  assign cnt1 = w_cnt[1];
  assign cnt2 = w_cnt[2];
  assign cnt3 = w_cnt[3];

endmodule

`default_nettype wire

// File: tb/tb_demultiplexer4x4_buf.sv
// ---------------------------------------------------------------------------
// tb_demultiplexer4x4_buf : directed and random stimulus against a queue-free
// per-channel reference model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_demultiplexer4x4_buf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic [1:0] sel;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] y0, y1, y2, y3;
  logic       v0, v1, v2, v3;
  logic [3:0] r;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;

  int total = 0;
  int bad   = 0;

  // Reference model: one word slot per channel plus a delivery tally.
  bit       m_full [4];
  bit [3:0] m_data [4];
  int       m_cnt  [4];

  demultiplexer4x4_buf #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .v0(v0), .v1(v1), .v2(v2), .v3(v3),
    .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] get_y(input int k);
    case (k)
      0: return y0;
      1: return y1;
      2: return y2;
      default: return y3;
    endcase
  endfunction

  function automatic logic get_v(input int k);
    case (k)
      0: return v0;
      1: return v1;
      2: return v2;
      default: return v3;
    endcase
  endfunction

  function automatic logic [7:0] get_cnt(input int k);
    case (k)
      0: return cnt0;
      1: return cnt1;
      2: return cnt2;
      default: return cnt3;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 1'b0;
      m_data[k] = 4'h0;
      m_cnt[k]  = 0;
    end
  endtask

  // One clock cycle: apply inputs, check in_ready, advance model, check outputs.
  task automatic drive(input logic rn, input logic [3:0] d, input logic [1:0] s,
                       input logic iv, input logic [3:0] rr);
    bit exp_rdy;
    bit acc;
    rst_n = rn; din = d; sel = s; in_valid = iv; r = rr;
    exp_rdy = rn && (!m_full[s] || rr[s]);
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else begin
      acc = iv && exp_rdy;
      for (int k = 0; k < 4; k++) begin
        if (m_full[k] && rr[k]) begin
          m_cnt[k]  = (m_cnt[k] + 1) % 256;
          m_full[k] = 1'b0;
        end
        if (acc && s == k[1:0]) begin
          m_full[k] = 1'b1;
          m_data[k] = d;
        end
      end
    end
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("v%0d", k),   {31'd0, get_v(k)},  {31'd0, m_full[k]});
      chk($sformatf("y%0d", k),   {28'd0, get_y(k)},  {28'd0, m_data[k]});
      chk($sformatf("cnt%0d", k), {24'd0, get_cnt(k)}, m_cnt[k]);
    end
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; din = '0; sel = '0; in_valid = 1'b0; r = '0;

    drive(1'b0, 4'h0, 2'd0, 1'b0, 4'h0);
    drive(1'b0, 4'h0, 2'd0, 1'b1, 4'hF);

    // Single load lands one cycle later on channel 2
    drive(1'b1, 4'hA, 2'd2, 1'b1, 4'h0);
    chk("req34_v2", {31'd0, v2}, 32'd1);
    chk("req34_y2", {28'd0, y2}, 32'hA);

    // Full channel blocks until its consumer is ready, then swaps in place
    drive(1'b1, 4'h5, 2'd2, 1'b1, 4'h0);
    chk("req35_hold", {28'd0, y2}, 32'hA);
    drive(1'b1, 4'h5, 2'd2, 1'b1, 4'b0100);
    chk("req35_y2", {28'd0, y2}, 32'h5);
    chk("req35_cnt2", {24'd0, cnt2}, 32'd1);
    drive(1'b1, 4'h0, 2'd0, 1'b0, 4'b0100);

    // Back-to-back stream on channel 1
    for (int i = 0; i < 16; i++) drive(1'b1, i[3:0], 2'd1, 1'b1, 4'b0010);
    drive(1'b1, 4'h0, 2'd1, 1'b0, 4'b0010);
    chk("req36_cnt1", {24'd0, cnt1}, 32'd16);

    // Stalled channels do not block another destination
    drive(1'b1, 4'h3, 2'd0, 1'b1, 4'h0);
    drive(1'b1, 4'h9, 2'd3, 1'b1, 4'h0);
    drive(1'b1, 4'h7, 2'd1, 1'b1, 4'h0);
    chk("req37_v0v3", {30'd0, v3, v0}, 32'd3);

    // Counter wrap on channel 3
    drive(1'b0, 4'h0, 2'd0, 1'b0, 4'h0);
    for (int i = 0; i < 256; i++) drive(1'b1, i[3:0], 2'd3, 1'b1, 4'b1000);
    drive(1'b1, 4'h0, 2'd3, 1'b0, 4'b1000);
    chk("req38_wrap", {24'd0, cnt3}, 32'd0);

    // Reset with every channel holding a word
    for (int k = 0; k < 4; k++) drive(1'b1, 4'hC, k[1:0], 1'b1, 4'h0);
    drive(1'b0, 4'hC, 2'd1, 1'b1, 4'hF);
    chk("req38_rst_v", {28'd0, v3, v2, v1, v0}, 32'd0);

    // Random traffic including occasional reset
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) != 0),
            4'($urandom), 2'($urandom), 1'($urandom), 4'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
